// File: rtl/pipe_skid_reg.sv
// Two-entry skid-buffered pipeline stage with a valid/ready handshake on both sides.
// The main entry drives the outputs directly from registers. The skid entry catches
// one extra item, so in_ready is decided from registered state only and never from
// out_ready. The stage also supports a synchronous flush with a selectable data
// policy and keeps a saturating stall counter for debug.
module pipe_skid_reg #(
  parameter int DATA_W     = 32,
  parameter int NUM_FIELDS = 7,
  parameter int FLUSH_MODE = 0,
  parameter int CNT_W      = 16,
  parameter int BW         = DATA_W * NUM_FIELDS
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [BW-1:0]    in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [BW-1:0]    out_data,
  output logic [1:0]       occupancy,
  output logic [CNT_W-1:0] stall_cnt
);

  logic          main_valid;
  logic          skid_valid;
  logic [BW-1:0] main_data;
  logic [BW-1:0] skid_data;
  logic          acc;
  logic          con;

  // Add one to the stall count, holding at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (&v) return v;
    return v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  // Handshake decode. in_ready looks only at registered skid state and flush.
  assign in_ready  = !skid_valid && !flush;
  assign acc       = in_valid && in_ready;
  assign con       = main_valid && out_ready;
  assign out_valid = main_valid;
  assign out_data  = main_data;
  assign occupancy = {1'b0, main_valid} + {1'b0, skid_valid};

  // Valid bits: EMPTY (0,0), ONE (1,0), FULL (1,1). (0,1) cannot be reached.
  always_ff @(posedge clk) begin
    if (reset) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (flush) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (!main_valid) begin
      if (acc) main_valid <= 1'b1;
    end else if (!skid_valid) begin
      if (acc && !con)      skid_valid <= 1'b1;
      else if (!acc && con) main_valid <= 1'b0;
    end else begin
      if (con) skid_valid <= 1'b0;
    end
  end

  // Data movement. Draining to EMPTY leaves main_data untouched on purpose.
  always_ff @(posedge clk) begin
    if (reset) begin
      main_data <= '0;
      skid_data <= '0;
    end else if (flush) begin
      if (FLUSH_MODE == 0) begin
        main_data <= '0;
        skid_data <= '0;
      end
    end else if (!main_valid) begin
      if (acc) main_data <= in_data;
    end else if (!skid_valid) begin
      if (acc && con)       main_data <= in_data;
      else if (acc && !con) skid_data <= in_data;
    end else begin
      if (con) main_data <= skid_data;
    end
  end

  // Count edges where the main entry is offered but refused. Flush does not clear it.
  always_ff @(posedge clk) begin
    if (reset)                      stall_cnt <= '0;
    else if (main_valid && !out_ready) stall_cnt <= sat_inc(stall_cnt);
  end

endmodule
